ifetch: RTL

- Instruction fetch front end; consumes the program counter value and drives its stall input.
- Issues fetch requests to instruction memory over a valid/ready request channel, then pairs in-order responses with their PCs.
- Buffers fetched instructions in a small queue and hands them to decode over a valid/ready channel.
- Handles redirects (branch/jump) by flushing buffered work and discarding stale in-flight responses.

---
 rtl/core_pkg.sv | 23 ++
 rtl/ifetch_if.sv | 71 +++++++
 rtl/ifetch_sync_fifo.sv | 77 +++++++
 rtl/ifetch.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core definitions for the instruction fetch front end.
//                XLEN  - address / PC width
//                ILEN  - instruction width
//                fetch_pkt_t - one fetched instruction paired with its PC
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // Entry of the instruction queue: the PC travels with its instruction so
  // decode always sees a matched pair.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_if
//  Description : Bundle of every non-clock/reset signal of the fetch unit.
//                PC side     : i_pc, o_stall, i_flush
//                Memory side : o_imem_req_valid/addr, i_imem_req_ready,
//                              i_imem_rsp_valid/data
//                Decode side : o_inst_valid, o_inst, o_inst_pc, i_inst_ready
//                Signal names keep the fetch unit's point of view: i_* are
//                driven into the fetch unit, o_* are driven by it.
//                modport master : the fetch unit itself
//                modport slave  : the surrounding core / memory / decode
//  Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);

  // program counter side
  logic [XLEN-1:0] i_pc;
  logic            o_stall;
  logic            i_flush;

  // instruction memory request channel
  logic            o_imem_req_valid;
  logic [XLEN-1:0] o_imem_req_addr;
  logic            i_imem_req_ready;

  // instruction memory response channel (no backpressure)
  logic            i_imem_rsp_valid;
  logic [ILEN-1:0] i_imem_rsp_data;

  // decode channel
  logic            o_inst_valid;
  logic [ILEN-1:0] o_inst;
  logic [XLEN-1:0] o_inst_pc;
  logic            i_inst_ready;

  modport master (
    input  i_pc,
    input  i_flush,
    input  i_imem_req_ready,
    input  i_imem_rsp_valid,
    input  i_imem_rsp_data,
    input  i_inst_ready,
    output o_stall,
    output o_imem_req_valid,
    output o_imem_req_addr,
    output o_inst_valid,
    output o_inst,
    output o_inst_pc
  );

  modport slave (
    output i_pc,
    output i_flush,
    output i_imem_req_ready,
    output i_imem_rsp_valid,
    output i_imem_rsp_data,
    output i_inst_ready,
    input  o_stall,
    input  o_imem_req_valid,
    input  o_imem_req_addr,
    input  o_inst_valid,
    input  o_inst,
    input  o_inst_pc
  );

endinterface
`default_nettype wire

// File: rtl/ifetch_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with synchronous flush and an occupancy
//                count. Push and pop in the same cycle are allowed at any
//                occupancy, including full (the popped slot is reused).
//                A push into a full FIFO without a pop is ignored, as is a
//                pop from an empty FIFO.
//  Ports       : i_clk    clock
//                i_rstn   synchronous active-low reset
//                i_flush  synchronous clear (wins over push/pop)
//                i_push   write i_din
//                i_din    write data
//                i_pop    remove head
//                o_dout   head data (valid when !o_empty)
//                o_empty  no entries
//                o_count  number of entries, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,   // power of two, >= 2
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // A full FIFO can still accept a write when its head leaves in the same
  // cycle: the read happens combinationally before the edge that overwrites.
  assign w_push = i_push && (!w_full || i_pop);
  assign w_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (i_rstn && !i_flush && w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch
//  Description : Instruction fetch front end. Issues one fetch request per
//                accepted PC, remembers the PCs of outstanding requests
//                (pcq), pairs in-order memory responses with those PCs and
//                buffers the result (ifq) for decode. A redirect (i_flush)
//                empties both queues and converts every outstanding request
//                into a pending drop so its late response is discarded.
//  Ports       : i_clk   clock, all state on rising edge
//                i_rstn  synchronous active-low reset
//                bus     ifetch_if.master:
//                  i_pc / o_stall / i_flush                 PC side
//                  o_imem_req_valid / o_imem_req_addr /
//                  i_imem_req_ready                          fetch request
//                  i_imem_rsp_valid / i_imem_rsp_data        fetch response
//                  o_inst_valid / o_inst / o_inst_pc /
//                  i_inst_ready                              decode side
//  Notes       : XLEN/ILEN must match core_pkg, whose fetch_pkt_t defines
//                the ifq entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch #(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int ILEN  = core_pkg::ILEN,
  parameter int DEPTH = 2   // power of two, >= 2
) (
  input  logic     i_clk,
  input  logic     i_rstn,
  ifetch_if.master bus
);

  import core_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;  // holds 0..DEPTH
  localparam int OW = CW + 2;             // holds the sum of three counters

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [CW-1:0]   r_drop_cnt;     // responses still owed for flushed requests
  logic [CW-1:0]   w_drop_flush;
  logic [CW-1:0]   w_drop_nxt;

  logic [CW-1:0]   w_pcq_count;
  logic            w_pcq_empty;
  logic [XLEN-1:0] w_pcq_head;

  logic [CW-1:0]   w_ifq_count;
  logic            w_ifq_empty;
  fetch_pkt_t      w_ifq_din;
  fetch_pkt_t      w_ifq_dout;

  logic [OW-1:0]   w_occ;
  logic            w_req_valid;
  logic            w_accept;
  logic            w_rsp;
  logic            w_rsp_drop;
  logic            w_rsp_take;
  logic            w_inst_valid;
  logic            w_ifq_pop;

  // --------------------------------------------------------------------------
  // Request side
  // --------------------------------------------------------------------------
  // Every request, buffered instruction and owed drop holds one slot, so
  // bounding their sum by DEPTH makes both queues overflow-free without
  // checking either one individually.
  assign w_occ = OW'(w_pcq_count) + OW'(w_ifq_count) + OW'(r_drop_cnt);

  assign w_req_valid = i_rstn && !bus.i_flush && (w_occ < OW'(DEPTH));
  assign w_accept    = w_req_valid && bus.i_imem_req_ready;

  assign bus.o_imem_req_valid = w_req_valid;
  assign bus.o_imem_req_addr  = bus.i_pc;
  // The PC advances exactly when its request is taken.
  assign bus.o_stall          = !w_accept;

  // --------------------------------------------------------------------------
  // Response side
  // --------------------------------------------------------------------------
  // Owed drops are always the oldest outstanding requests, so they are
  // retired first. A response in a flush cycle is never kept: it is absorbed
  // by the drop-count update below instead.
  assign w_rsp      = i_rstn && bus.i_imem_rsp_valid;
  assign w_rsp_drop = w_rsp && (r_drop_cnt != '0);
  assign w_rsp_take = w_rsp && !w_rsp_drop && !bus.i_flush && !w_pcq_empty;

  assign w_ifq_din.pc   = w_pcq_head;
  assign w_ifq_din.inst = bus.i_imem_rsp_data;

  // On flush every outstanding request becomes an owed drop, less the one
  // whose response is arriving right now. The total never exceeds DEPTH,
  // so CW bits suffice without widening.
  assign w_drop_flush = r_drop_cnt + w_pcq_count
                      - CW'(w_rsp && ((r_drop_cnt != '0) || (w_pcq_count != '0)));

  always_comb begin
    w_drop_nxt = r_drop_cnt;
    if (bus.i_flush) begin
      w_drop_nxt = w_drop_flush;
    end else if (w_rsp_drop) begin
      w_drop_nxt = r_drop_cnt - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_drop_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // PC queue: one entry per outstanding (non-dropped) request
  // --------------------------------------------------------------------------
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pcq (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_flush (bus.i_flush),
    .i_push  (w_accept),
    .i_din   (bus.i_pc),
    .i_pop   (w_rsp_take),
    .o_dout  (w_pcq_head),
    .o_empty (w_pcq_empty),
    .o_count (w_pcq_count)
  );

  // --------------------------------------------------------------------------
  // Instruction queue towards decode
  // --------------------------------------------------------------------------
  // A decode handshake in the flush cycle targets a stale instruction; it is
  // not counted as consumed (the flush clears it anyway).
  assign w_inst_valid = i_rstn && !w_ifq_empty;
  assign w_ifq_pop    = w_inst_valid && bus.i_inst_ready && !bus.i_flush;

  sync_fifo #(
    .WIDTH ($bits(fetch_pkt_t)),
    .DEPTH (DEPTH)
  ) u_ifq (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_flush (bus.i_flush),
    .i_push  (w_rsp_take),
    .i_din   (w_ifq_din),
    .i_pop   (w_ifq_pop),
    .o_dout  (w_ifq_dout),
    .o_empty (w_ifq_empty),
    .o_count (w_ifq_count)
  );

  // Data outputs are zeroed when nothing is offered so decode never sees
  // stale storage contents (and so they read zero throughout reset).
  assign bus.o_inst_valid = w_inst_valid;
  assign bus.o_inst       = w_inst_valid ? w_ifq_dout.inst : '0;
  assign bus.o_inst_pc    = w_inst_valid ? w_ifq_dout.pc   : '0;

  // --------------------------------------------------------------------------
  // Protocol check: a response must always belong to some request
  // --------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_rsp_tracked: assert property (
    @(posedge i_clk) disable iff (!i_rstn)
      bus.i_imem_rsp_valid |-> ((r_drop_cnt != '0) || !w_pcq_empty)
  );
`endif

endmodule
`default_nettype wire
